// File: rtl/snake_pkg.sv
// snake_pkg: field limits, widths, shared payload types and the make_item state encoding.
package snake_pkg;

    localparam int unsigned XSIZE    = 48;
    localparam int unsigned YSIZE    = 63;
    localparam int unsigned MAX_SIZE = 3072;
    localparam int unsigned CW       = 6;
    localparam int unsigned SW       = 9;
    localparam int unsigned AW       = 12;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DRAW = 2'b01,
        SCAN = 2'b10,
        DONE = 2'b11
    } mi_state_e;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } coord_t;

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left every clock.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    output logic [15:0] o_Q
);

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) r_q <= SEED;
        else        r_q <= {r_q[14:0], w_fb};
    end

    assign o_Q = r_q;

endmodule

// File: rtl/make_item.sv
// make_item: places the food item on a free field cell using LFSR draws and a body-queue scan.
// Optional MAKE_ITEM_TIMEOUT_EN bounds retries at MAX_TRY and reports o_Full with item (0,0).
module make_item
    import snake_pkg::*;
#(
    parameter int unsigned XMAX      = XSIZE,
    parameter int unsigned YMAX      = YSIZE,
    parameter int unsigned MAX_SIZE  = snake_pkg::MAX_SIZE,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
`ifdef MAKE_ITEM_TIMEOUT_EN
    ,
    parameter int unsigned MAX_TRY   = 255
`endif
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst,
    input  logic                        i_Req,
    input  logic [CW-1:0]               i_Head_x,
    input  logic [CW-1:0]               i_Head_y,
    input  logic [SW-1:0]               i_Size,
    output logic [$clog2(MAX_SIZE)-1:0] o_Body_Addr,
    input  logic [CW-1:0]               i_Body_x,
    input  logic [CW-1:0]               i_Body_y,
    output logic [CW-1:0]               o_Item_x,
    output logic [CW-1:0]               o_Item_y,
    output logic                        o_isMakeItem_Done,
`ifdef MAKE_ITEM_TIMEOUT_EN
    output logic                        o_Full,
`endif
    output logic                        o_Busy
);

    localparam int unsigned AWL = $clog2(MAX_SIZE);
    localparam int unsigned CW1 = CW + 1;

    mi_state_e        r_state, w_next;
    logic [15:0]      w_lfsr;
    coord_t           w_draw, r_cand, w_cand_n, r_item, w_item_n;
    logic [AWL-1:0]   r_addr, w_addr_n;
    logic             r_done, w_done_n, r_busy, w_busy_n;
    logic             w_draw_bad, w_hit, w_last;
    logic             w_unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .o_Q   (w_lfsr)
    );

    assign w_draw        = {w_lfsr[5:0], w_lfsr[11:6]};
    assign w_unused_lfsr = ^w_lfsr[15:12];

    // Off-field or head-occupied draws are discarded; widened compare keeps the limits general.
    assign w_draw_bad = (w_draw.x == '0) || ({1'b0, w_draw.x} > CW1'(XMAX)) ||
                        (w_draw.y == '0) || ({1'b0, w_draw.y} > CW1'(YMAX)) ||
                        ((w_draw.x == i_Head_x) && (w_draw.y == i_Head_y));
    assign w_hit  = (r_cand.x == i_Body_x) && (r_cand.y == i_Body_y);
    assign w_last = (r_addr == (AWL'(i_Size) - AWL'(1)));

`ifdef MAKE_ITEM_TIMEOUT_EN
    logic [7:0] r_try, w_try_n;
    logic       r_full, w_full_n;
    logic       w_reject, w_timeout;

    assign w_reject  = ((r_state == DRAW) && w_draw_bad) || ((r_state == SCAN) && w_hit);
    assign w_timeout = w_reject && ((r_try + 8'd1) == 8'(MAX_TRY));
`endif

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (i_Req) w_next = DRAW;
            DRAW: if (!w_draw_bad) w_next = (i_Size == '0) ? DONE : SCAN;
            SCAN: begin
                if (w_hit)       w_next = DRAW;
                else if (w_last) w_next = DONE;
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
`ifdef MAKE_ITEM_TIMEOUT_EN
        if (w_timeout) w_next = DONE;
`endif
    end

    // Next values of all registered outputs and datapath registers.
    always_comb begin
        w_cand_n = r_cand;
        w_addr_n = r_addr;
        w_item_n = r_item;
        w_done_n = (w_next == DONE);
        w_busy_n = (w_next != IDLE);
        case (r_state)
            DRAW: begin
                w_cand_n = w_draw;
                w_addr_n = '0;
            end
            SCAN: if (!w_hit && !w_last) w_addr_n = r_addr + AWL'(1);
            default: ;
        endcase
        if (w_next == DONE) w_item_n = (r_state == DRAW) ? w_draw : r_cand;
`ifdef MAKE_ITEM_TIMEOUT_EN
        w_try_n  = r_try;
        w_full_n = r_full;
        if ((r_state == IDLE) && i_Req) begin
            w_try_n  = '0;
            w_full_n = 1'b0;
        end else if (w_reject) begin
            w_try_n = r_try + 8'd1;
        end
        if (w_timeout) begin
            w_item_n = '0;
            w_full_n = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_cand <= '0;
            r_addr <= '0;
            r_item <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_cand <= w_cand_n;
            r_addr <= w_addr_n;
            r_item <= w_item_n;
            r_done <= w_done_n;
            r_busy <= w_busy_n;
        end
    end

`ifdef MAKE_ITEM_TIMEOUT_EN
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_try  <= '0;
            r_full <= 1'b0;
        end else begin
            r_try  <= w_try_n;
            r_full <= w_full_n;
        end
    end

    assign o_Full = r_full;
`endif

    assign o_Body_Addr       = r_addr;
    assign o_Item_x          = r_item.x;
    assign o_Item_y          = r_item.y;
    assign o_isMakeItem_Done = r_done;
    assign o_Busy            = r_busy;

endmodule

// File: tb/tb_make_item.sv
// tb_make_item: directed and randomized requests checked against a draw-level placement model.
`timescale 1ns/1ps
module tb_make_item;

    localparam int MAXTRY_TB = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        req   = 1'b0;
    logic [5:0]  hx    = '0;
    logic [5:0]  hy    = '0;
    logic [8:0]  size  = '0;
    logic [11:0] addr;
    logic [5:0]  body_x, body_y, item_x, item_y;
    logic        done, busy;
`ifdef MAKE_ITEM_TIMEOUT_EN
    logic        full;
    logic        dfull;
`endif

    logic [5:0]  bx [4096];
    logic [5:0]  by [4096];
    logic        all_match = 1'b0;
    logic [5:0]  mx = '0;
    logic [5:0]  my = '0;
    logic [15:0] m_lfsr;

    int          checks = 0;
    int          errors = 0;
    logic [5:0]  pcx [2048];
    logic [5:0]  pcy [2048];
    logic [11:0] alog [2048];
    int          e_cyc, first_done, ndone, nidle;
    logic [5:0]  e_x, e_y, dx, dy, fl_x, fl_y;
    logic        e_full;

    always #5 clk = ~clk;

    assign body_x = all_match ? mx : bx[addr];
    assign body_y = all_match ? my : by[addr];

    make_item #(
        .LFSR_SEED(16'hACE1)
`ifdef MAKE_ITEM_TIMEOUT_EN
        , .MAX_TRY(MAXTRY_TB)
`endif
    ) dut (
        .i_Clk             (clk),
        .i_Rst             (rst_n),
        .i_Req             (req),
        .i_Head_x          (hx),
        .i_Head_y          (hy),
        .i_Size            (size),
        .o_Body_Addr       (addr),
        .i_Body_x          (body_x),
        .i_Body_y          (body_y),
        .o_Item_x          (item_x),
        .o_Item_y          (item_y),
        .o_isMakeItem_Done (done),
`ifdef MAKE_ITEM_TIMEOUT_EN
        .o_Full            (full),
`endif
        .o_Busy            (busy)
    );

    // LFSR reference: polynomial x^16+x^14+x^13+x^11+1, left shift.
    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lstep(m_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input int cx, input int cy);
        return (cx >= 1) && (cx <= 48) && (cy >= 1) && (cy <= 63) &&
               !((cx == int'(hx)) && (cy == int'(hy)));
    endfunction

    // First legal candidate from a given LFSR value; returns its draw index.
    function automatic int first_legal(input logic [15:0] start);
        logic [15:0] v = start;
        for (int i = 0; i < 200; i++) begin
            if (legal(int'(v[5:0]), int'(v[11:6]))) begin
                fl_x = v[5:0];
                fl_y = v[11:6];
                return i;
            end
            v = lstep(v);
        end
        return -1;
    endfunction

    // Placement model: one draw per clock, each legal draw scanned against the body one entry per clock.
    function automatic void predict(input logic [15:0] start);
        logic [15:0] v = start;
        int t = 0;
        int cx, cy;
        bit rej;
`ifdef MAKE_ITEM_TIMEOUT_EN
        int tries = 0;
`endif
        e_cyc = -1; e_x = '0; e_y = '0; e_full = 1'b0;
        while (t < 1500) begin
            cx  = int'(v[5:0]);
            cy  = int'(v[11:6]);
            rej = !legal(cx, cy);
            if (!rej) begin
                for (int k = 0; k < int'(size); k++) begin
                    t++;
                    v = lstep(v);
                    pcx[t] = 6'(cx);
                    pcy[t] = 6'(cy);
                    if (all_match || ((int'(bx[k]) == cx) && (int'(by[k]) == cy))) begin
                        rej = 1'b1;
                        break;
                    end
                end
            end
            if (!rej) begin
                e_cyc = t + 1; e_x = 6'(cx); e_y = 6'(cy);
                return;
            end
`ifdef MAKE_ITEM_TIMEOUT_EN
            tries++;
            if (tries == MAXTRY_TB) begin
                e_cyc = t + 1; e_full = 1'b1;
                return;
            end
`endif
            t++;
            v = lstep(v);
        end
    endfunction

    // Called at the falling edge of the first DRAW cycle; ends at the falling edge after DONE.
    task automatic run_from_draw(input string tag, input bit pulses);
        predict(m_lfsr);
        if (e_cyc < 0) begin
            checks++; errors++;
            $error("FAIL %s model bound observed=-1 expected=done", tag);
            return;
        end
        first_done = -1; ndone = 0; nidle = 0; dx = '0; dy = '0;
        for (int t = 0; t <= e_cyc; t++) begin
            if (all_match) begin mx = pcx[t]; my = pcy[t]; end
            if (pulses) req = (t >= 1) && (t <= 3);
            alog[t] = addr;
            if (done) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = t; dx = item_x; dy = item_y;
`ifdef MAKE_ITEM_TIMEOUT_EN
                    dfull = full;
`endif
                end
            end
            if (!busy) nidle++;
            @(negedge clk);
        end
        chk({tag, "/done_cycle"}, first_done, e_cyc);
        chk({tag, "/done_count"}, ndone, 1);
        chk({tag, "/item_x"}, dx, e_x);
        chk({tag, "/item_y"}, dy, e_y);
        chk({tag, "/busy_gaps"}, nidle, 0);
        chk({tag, "/busy_after"}, busy, 0);
        chk({tag, "/done_after"}, done, 0);
`ifdef MAKE_ITEM_TIMEOUT_EN
        chk({tag, "/full"}, dfull, e_full);
`endif
    endtask

    task automatic do_search(input string tag, input bit pulses);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        run_from_draw(tag, pulses);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int d, k, waited, dpulse;
        for (int i = 0; i < 4096; i++) begin bx[i] = '0; by[i] = '0; end

        #1 rst_n = 1'b0;
        #1;
        chk("reset/item_x", item_x, 0);
        chk("reset/item_y", item_y, 0);
        chk("reset/done", done, 0);
        chk("reset/busy", busy, 0);
        chk("reset/addr", addr, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty body: only range and head rejections apply.
        hx = 6'd24; hy = 6'd32; size = 9'd0;
        do_search("size0", 1'b0);
        chk("size0/range", (dx >= 6'd1) && (dx <= 6'd48) && (dy != 6'd0), 1);
        chk("size0/not_head", (dx == 6'd24) && (dy == 6'd32), 0);

        // Whole body sits on the first legal candidate.
        hx = 6'd1; hy = 6'd1; size = 9'd3;
        d = first_legal(lstep(m_lfsr));
        for (int i = 0; i < 3; i++) begin bx[i] = fl_x; by[i] = fl_y; end
        do_search("body_hit", 1'b0);
        chk("body_hit/not_body", (dx == fl_x) && (dy == fl_y), 0);
        chk("body_hit/addr0", alog[e_cyc-3], 0);
        chk("body_hit/addr1", alog[e_cyc-2], 1);
        chk("body_hit/addr2", alog[e_cyc-1], 2);
        for (int i = 0; i < 3; i++) begin bx[i] = '0; by[i] = '0; end

        // Head placed on the first legal candidate.
        hx = '0; hy = '0; size = 9'd2;
        d = first_legal(lstep(m_lfsr));
        hx = fl_x; hy = fl_y;
        do_search("head_hit", 1'b0);
        chk("head_hit/not_head", (dx == hx) && (dy == hy), 0);
        if (d >= 0) chk("head_hit/addr_stays0", alog[d+1], 0);

        // Requests while busy are ignored; an immediate re-request starts a new search.
        hx = 6'($urandom_range(1, 48)); hy = 6'($urandom_range(1, 63)); size = 9'd20;
        for (int i = 0; i < 20; i++) begin
            bx[i] = 6'($urandom_range(1, 48)); by[i] = 6'($urandom_range(1, 63));
        end
        do_search("busy_pulses", 1'b1);
        size = 9'd5;
        do_search("back_to_back", 1'b0);

        // Request held high: one idle cycle after DONE, then a fresh search.
        size = 9'd4;
        req = 1'b1;
        @(negedge clk);
        run_from_draw("held", 1'b0);
        @(negedge clk);
        chk("held/restart_busy", busy, 1);
        req = 1'b0;
        run_from_draw("held2", 1'b0);

        // Randomized positions, lengths and bodies, some seeded with a colliding entry.
        for (int n = 0; n < 6; n++) begin
            size = 9'($urandom_range(0, 12));
            hx = 6'($urandom_range(1, 48)); hy = 6'($urandom_range(1, 63));
            for (int i = 0; i < 12; i++) begin
                bx[i] = 6'($urandom_range(1, 48)); by[i] = 6'($urandom_range(1, 63));
            end
            if (size != 0) begin
                d = first_legal(lstep(m_lfsr));
                k = $urandom_range(0, int'(size) - 1);
                bx[k] = fl_x; by[k] = fl_y;
            end
            do_search($sformatf("rand%0d", n), 1'b0);
        end

        // Reset in the middle of a scan.
        chk("prereset/item_nonzero", (item_x != 6'd0) || (item_y != 6'd0), 1);
        size = 9'd30;
        for (int i = 0; i < 30; i++) begin
            bx[i] = 6'($urandom_range(1, 48)); by[i] = 6'($urandom_range(1, 63));
        end
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        waited = 0;
        while (!(busy && addr >= 12'd2) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("midreset/reached_scan", waited < 200, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset/item_x", item_x, 0);
        chk("midreset/item_y", item_y, 0);
        chk("midreset/done", done, 0);
        chk("midreset/busy", busy, 0);
        chk("midreset/addr", addr, 0);
        dpulse = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dpulse++;
        end
        chk("midreset/no_done", dpulse, 0);
        rst_n = 1'b1;
        @(negedge clk);
        size = 9'd3;
        do_search("post_reset", 1'b0);

`ifdef MAKE_ITEM_TIMEOUT_EN
        // Every body entry matches: retries exhaust and the field is reported full.
        size = 9'd3;
        all_match = 1'b1;
        do_search("timeout", 1'b0);
        chk("timeout/item_x", item_x, 0);
        all_match = 1'b0;
        size = 9'd0;
        req = 1'b1;
        @(negedge clk);
        chk("timeout/full_cleared", full, 0);
        req = 1'b0;
        run_from_draw("after_timeout", 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
